// File: rtl/video_timing_gen.sv
// video_timing_gen: raster timing and test-pattern RGB source for the overlay path.
// Define VTG_CROSSHATCH_EN to build the 32-px crosshatch for pattern 3 (otherwise it is black).
module video_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 29,
  parameter int BAR_W    = 100
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cen_i,
  input  logic [1:0]  pat_sel_i,
  input  logic [23:0] solid_rgb_i,
  output logic [2:0]  dvh_sync_o,
  output logic [1:0]  vh_blank_o,
  output logic [23:0] vid_rgb_o,
  output logic        sof_o,
  output logic [15:0] frame_cnt_o
);
  localparam logic [11:0] HA  = 12'(H_ACTIVE);
  localparam logic [11:0] HS0 = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS1 = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] HT1 = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] VA  = 12'(V_ACTIVE);
  localparam logic [11:0] VS0 = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS1 = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [11:0] VT1 = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] BW1 = 12'(BAR_W - 1);
  // index 0 is the leftmost bar (white)
  localparam logic [7:0][23:0] BARS = {24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
                                       24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF};
  logic [11:0] h_cnt, v_cnt, bar_px;
  logic [2:0]  bar_idx;
  logic [15:0] frame_cnt;
  logic [1:0]  pat_q, pat;
  logic        h_wrap, v_wrap, hblank, vblank, de, hsync, vsync, first;
  logic [23:0] grid, rgb;
`ifdef VTG_CROSSHATCH_EN
  assign grid = (h_cnt[4:0] == 5'd0 || v_cnt[4:0] == 5'd0) ? 24'hFFFFFF : 24'h000000;
`else
  assign grid = 24'h000000;
`endif
  always_comb begin
    h_wrap = h_cnt == HT1;
    v_wrap = v_cnt == VT1;
    hblank = h_cnt >= HA;
    vblank = v_cnt >= VA;
    de     = !hblank && !vblank;
    hsync  = h_cnt >= HS0 && h_cnt < HS1;
    vsync  = v_cnt >= VS0 && v_cnt < VS1;
    first  = h_cnt == 12'd0 && v_cnt == 12'd0;
    // the new selection applies from the first pixel of the frame it is latched on
    pat    = first ? pat_sel_i : pat_q;
    rgb    = !de ? 24'h000000 :
             pat == 2'd0 ? BARS[bar_idx] :
             pat == 2'd1 ? solid_rgb_i :
             pat == 2'd2 ? {h_cnt[7:0], v_cnt[7:0], frame_cnt[7:0]} : grid;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_cnt   <= '0;
      bar_px      <= '0;
      bar_idx     <= '0;
      pat_q       <= '0;
      dvh_sync_o  <= '0;
      vh_blank_o  <= '0;
      vid_rgb_o   <= '0;
      sof_o       <= 1'b0;
      frame_cnt_o <= '0;
    end else if (cen_i) begin
      h_cnt <= h_wrap ? '0 : h_cnt + 12'd1;
      if (h_wrap) v_cnt <= v_wrap ? '0 : v_cnt + 12'd1;
      if (h_wrap && v_wrap) frame_cnt <= frame_cnt + 16'd1;
      if (first) pat_q <= pat_sel_i;
      bar_px <= (hblank || bar_px == BW1) ? '0 : bar_px + 12'd1;
      bar_idx <= hblank ? '0 : bar_px == BW1 ? bar_idx + 3'd1 : bar_idx;
      dvh_sync_o  <= {de, vsync, hsync};
      vh_blank_o  <= {vblank, hblank};
      vid_rgb_o   <= rgb;
      sof_o       <= first;
      frame_cnt_o <= frame_cnt;
    end
  end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed scoreboard bench for video_timing_gen on a reduced raster.
module tb_video_timing_gen;
  localparam int HA = 40, HF = 4, HS = 6, HB = 4;
  localparam int VA = 10, VF = 2, VS = 3, VB = 2;
  localparam int BW = 5;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        cen_i = 1'b0;
  logic [1:0]  pat_sel_i = '0;
  logic [23:0] solid_rgb_i = '0;
  logic [2:0]  dvh_sync_o;
  logic [1:0]  vh_blank_o;
  logic [23:0] vid_rgb_o;
  logic        sof_o;
  logic [15:0] frame_cnt_o;
  logic [45:0] obs;
  logic [45:0] q[$];
  logic [45:0] last_exp = '0;
  logic [23:0] pix [HT][VT];
  int checks = 0, errors = 0;
  int mh = 0, mv = 0, mf = 0;
  logic [1:0] mpat = '0;
  int de_n = 0, hs_n = 0, vs_n = 0;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .BAR_W(BW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cen_i(cen_i), .pat_sel_i(pat_sel_i),
    .solid_rgb_i(solid_rgb_i), .dvh_sync_o(dvh_sync_o), .vh_blank_o(vh_blank_o),
    .vid_rgb_o(vid_rgb_o), .sof_o(sof_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk_i = ~clk_i;
  assign obs = {dvh_sync_o, vh_blank_o, vid_rgb_o, sof_o, frame_cnt_o};

  task automatic chk(input string tag, input logic [45:0] got, input logic [45:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // one clock; with c=1 the model predicts the next output word and queues it
  task automatic step(input logic c, input logic [1:0] p, input logic [23:0] s, input string tag);
    logic [45:0] e;
    logic [23:0] rgb;
    logic [2:0]  bi;
    logic        hb, vb, de, hsy, vsy, first;
    int          eh, ev;
    cen_i = c;
    pat_sel_i = p;
    solid_rgb_i = s;
    eh = mh;
    ev = mv;
    if (c) begin
      first = mh == 0 && mv == 0;
      if (first) mpat = p;
      hb  = mh >= HA;
      vb  = mv >= VA;
      de  = !hb && !vb;
      hsy = mh >= HA + HF && mh < HA + HF + HS;
      vsy = mv >= VA + VF && mv < VA + VF + VS;
      bi  = 3'(mh / BW);
      case (mpat)
        2'd0: rgb = {{8{~bi[1]}}, {8{~bi[2]}}, {8{~bi[0]}}};
        2'd1: rgb = s;
        2'd2: rgb = {8'(mh), 8'(mv), 8'(mf)};
`ifdef VTG_CROSSHATCH_EN
        default: rgb = (mh % 32 == 0 || mv % 32 == 0) ? 24'hFFFFFF : 24'h000000;
`else
        default: rgb = 24'h000000;
`endif
      endcase
      if (!de) rgb = 24'h000000;
      q.push_back({de, vsy, hsy, vb, hb, rgb, first, 16'(mf)});
      if (mh == HT - 1) begin
        mh = 0;
        if (mv == VT - 1) begin mv = 0; mf++; end else mv++;
      end else mh++;
    end
    @(posedge clk_i);
    #1;
    if (c) begin
      e = q.pop_front();
      last_exp = e;
      pix[eh][ev] = vid_rgb_o;
      de_n += int'(dvh_sync_o[2]);
      vs_n += int'(dvh_sync_o[1]);
      hs_n += int'(dvh_sync_o[0]);
    end
    chk(c ? tag : {tag, "_hold"}, obs, last_exp);
  endtask

  task automatic run(input int n, input logic [1:0] p, input logic [23:0] s, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, p, s, tag);
  endtask

  initial begin
    int k;
    logic c;
    #2 rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("reset", obs, 46'h0);
    rst_ni = 1'b1;
    run(2 * FR, 2'd0, 24'h0, "bars");
    chk("de_cycles", 46'(de_n), 46'(2 * HA * VA));
    chk("hsync_cycles", 46'(hs_n), 46'(2 * VT * HS));
    chk("vsync_cycles", 46'(vs_n), 46'(2 * VS * HT));
    chk("bar0", 46'(pix[0][0]), 46'h00FFFFFF);
    chk("bar3", 46'(pix[19][5]), 46'h0000FF00);
    chk("bar7", 46'(pix[37][9]), 46'h0);
    chk("blank_rgb", 46'(pix[45][2]), 46'h0);
    run(FR, 2'd1, 24'h123456, "solid");
    chk("solid_mid", 46'(pix[10][4]), 46'h00123456);
    chk("solid_last", 46'(pix[HA-1][VA-1]), 46'h00123456);
    run(5 * HT, 2'd0, 24'h0, "switch_pre");
    run(FR - 5 * HT, 2'd2, 24'h0, "switch_post");
    chk("bars_persist", 46'(pix[10][7]), 46'h0000FFFF);
    run(FR, 2'd2, 24'h0, "grad");
    chk("grad_5_3", 46'(pix[5][3]), 46'h00050304);
    k = 0;
    while (k < FR) begin
      c = 1'($urandom_range(0, 1));
      step(c, 2'd2, 24'h0, "stall");
      if (c) k++;
    end
    chk("stall_grad_5_3", 46'(pix[5][3]), 46'h00050305);
    run(FR, 2'd3, 24'h0, "xhatch");
`ifdef VTG_CROSSHATCH_EN
    chk("xhatch_32_7", 46'(pix[32][7]), 46'h00FFFFFF);
`else
    chk("xhatch_32_7", 46'(pix[32][7]), 46'h0);
`endif
    chk("xhatch_33_7", 46'(pix[33][7]), 46'h0);
    run(2 * HT + 17, 2'd0, 24'h0, "pre_rst");
    rst_ni = 1'b0;
    #1;
    chk("rst_async", obs, 46'h0);
    @(posedge clk_i);
    #1;
    chk("rst_hold", obs, 46'h0);
    rst_ni = 1'b1;
    mh = 0;
    mv = 0;
    mf = 0;
    mpat = '0;
    last_exp = '0;
    step(1'b1, 2'd0, 24'h0, "post_rst");
    chk("post_rst_sof", 46'(sof_o), 46'h1);
    chk("post_rst_de", 46'(dvh_sync_o[2]), 46'h1);
    chk("post_rst_fc", 46'(frame_cnt_o), 46'h0);
    run(3 * HT, 2'd0, 24'h0, "post_rst_run");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
